// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation search block:
// the FSM state encoding and the default search word width.
package sar_search_pkg;

    localparam int unsigned DefaultN = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StTest = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/sar_search_cmp.sv
// n-bit unsigned magnitude comparator: flags relate ip1 (target) to ip2 (trial).
// Used outside sar_search to close the search loop.
module sar_search_cmp
    import sar_search_pkg::*;
#(
    parameter int unsigned n = DefaultN
) (
    input  logic [n-1:0] ip1_i,
    input  logic [n-1:0] ip2_i,
    output logic         gt_o,
    output logic         eq_o,
    output logic         lt_o
);

    assign gt_o = ip1_i >  ip2_i;
    assign eq_o = ip1_i == ip2_i;
    assign lt_o = ip1_i <  ip2_i;

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search: resolves one bit of the target per TEST cycle
// from an external comparator, terminating early on equality.
module sar_search
    import sar_search_pkg::*;
#(
    parameter int unsigned n = DefaultN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         cmp_gt,
    input  logic         cmp_eq,
    input  logic         cmp_lt,
    output logic [n-1:0] trial,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] result,
    output logic         exact
);

    localparam int unsigned IdxW = $clog2(n);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(n - 1);
    localparam logic [n-1:0] One = {{(n-1){1'b0}}, 1'b1};
    localparam logic [n-1:0] MsbMask = One << (n - 1);

    state_e          state_q, state_d;
    logic [n-1:0]    trial_q, trial_d;
    logic [n-1:0]    result_q, result_d;
    logic            exact_q, exact_d;
    logic [IdxW-1:0] idx_q, idx_d;

    logic [n-1:0]    cur_mask;
    logic [n-1:0]    low_mask;
    logic [n-1:0]    resolved;

    assign cur_mask = One << idx_q;
    assign low_mask = cur_mask >> 1;

    // Bit decision for the current index; gt wins over lt, no flag counts as lt.
    always_comb begin
        resolved = trial_q & ~cur_mask;
        if (cmp_gt) begin
            resolved = trial_q;
        end else if (cmp_lt) begin
            resolved = trial_q & ~cur_mask;
        end
    end

    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        result_d = result_q;
        exact_d  = exact_q;
        idx_d    = idx_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StTest;
                    trial_d = MsbMask;
                    idx_d   = IdxMax;
                    exact_d = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
            StTest: begin
                if (cmp_eq) begin
                    result_d = trial_q;
                    exact_d  = 1'b1;
                    state_d  = StDone;
                end else if (idx_q == '0) begin
                    trial_d  = resolved;
                    result_d = resolved;
                    exact_d  = 1'b0;
                    state_d  = StDone;
                end else begin
                    trial_d = resolved | low_mask;
                    idx_d   = idx_q - IdxW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            trial_q  <= '0;
            result_q <= '0;
            exact_q  <= 1'b0;
            idx_q    <= IdxMax;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            exact_q  <= exact_d;
            idx_q    <= idx_d;
        end
    end

    assign trial  = trial_q;
    assign result = result_q;
    assign exact  = exact_q;
    assign busy   = (state_q == StTest);
    assign done   = (state_q == StDone);

endmodule

// File: tb/tb_sar_search.sv
// Scoreboard bench for sar_search closed through the magnitude comparator;
// a monitor pops expected result/exact/latency on every done pulse.
module tb_sar_search;
    import sar_search_pkg::*;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] target;
    logic [N-1:0] trial;
    logic [N-1:0] result;
    logic         busy;
    logic         done;
    logic         exact;
    logic         cmp_gt;
    logic         cmp_eq;
    logic         cmp_lt;

    typedef struct {
        logic [N-1:0] res;
        logic         ex;
        int           lat;
        int           t0;
    } exp_t;

    exp_t         sb_q[$];
    logic [N-1:0] tr_exp[$];
    exp_t         mon_e;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pops  = 0;

    sar_search #(.n(N)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cmp_gt (cmp_gt),
        .cmp_eq (cmp_eq),
        .cmp_lt (cmp_lt),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result),
        .exact  (exact)
    );

    sar_search_cmp #(.n(N)) u_cmp (
        .ip1_i (target),
        .ip2_i (trial),
        .gt_o  (cmp_gt),
        .eq_o  (cmp_eq),
        .lt_o  (cmp_lt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: trial sequence while busy, and result/exact/latency on done.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (busy && tr_exp.size() > 0) begin
                    check("trial", trial, tr_exp.pop_front());
                end
                if (done) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", done, 0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("result", result, mon_e.res);
                        check("exact", exact, mon_e.ex);
                        check("latency", cyc - mon_e.t0, mon_e.lat);
                        check("busy_with_done", busy, 0);
                        pops++;
                    end
                end
            end
        end
    end

    task automatic launch(input logic [N-1:0] tgt, input logic [N-1:0] res, input logic ex,
                          input int k);
        @(negedge clk);
        target = tgt;
        start  = 1'b1;
        sb_q.push_back('{res: res, ex: ex, lat: k + 1, t0: cyc});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int p0;
        int n_cyc;
        p0    = pops;
        n_cyc = 0;
        while (pops == p0 && n_cyc < budget) begin
            @(posedge clk);
            n_cyc++;
        end
        if (pops == p0) check("done_timeout", pops - p0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic push_trials(input logic [8*N-1:0] seq);
        for (int i = 7; i >= 0; i--) tr_exp.push_back(seq[i*N +: N]);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        target = '0;
        #2;
        check("rst_trial", trial, 0);
        check("rst_result", result, 0);
        check("rst_exact", exact, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        push_trials({8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hB8, 8'hB4, 8'hB6, 8'hB5});
        launch(8'hB5, 8'hB5, 1'b1, 8);
        wait_done(30);

        launch(8'h80, 8'h80, 1'b1, 1);
        wait_done(30);

        launch(8'h00, 8'h00, 1'b0, 8);
        wait_done(30);

        push_trials({8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF});
        launch(8'hFF, 8'hFF, 1'b1, 8);
        wait_done(30);

        launch(8'h7F, 8'h7F, 1'b1, 8);
        wait_done(30);

        // Second start during TEST cycle 3 must be ignored.
        @(negedge clk);
        target = 8'h3C;
        start  = 1'b1;
        sb_q.push_back('{res: 8'h3C, ex: 1'b1, lat: 7, t0: cyc});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(30);
        repeat (10) @(negedge clk);

        // Abort 0x5A with reset in TEST cycle 4; no done may follow.
        @(negedge clk);
        target = 8'h5A;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_rst", busy, 1);
        #1 rst = 1'b1;
        #1;
        check("abort_trial", trial, 0);
        check("abort_result", result, 0);
        check("abort_exact", exact, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        launch(8'h5A, 8'h5A, 1'b1, 7);
        wait_done(30);

        check("sb_empty", sb_q.size(), 0);
        check("trial_q_empty", tr_exp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
